// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Request/broadcast bundle between the functional units and the CDB arbiter.
//   i_fu_valid        : per-source broadcast request
//   i_fu_tag_flatten  : source k tag at [k*BW_TAG +: BW_TAG]
//   i_fu_data_flatten : source k data at [k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA]
//   o_fu_ready        : per-source grant (one-hot or zero)
//   o_cdb_valid/tag/data/src : registered Common Data Bus broadcast
// master = source side (drives requests), slave = arbiter side.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int NUM_FU            = 4,
    parameter int BW_TAG            = 4,
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_FU_IDX         = $clog2(NUM_FU)
);
    logic [NUM_FU-1:0]                   i_fu_valid;
    logic [NUM_FU*BW_TAG-1:0]            i_fu_tag_flatten;
    logic [NUM_FU*BW_PROCESSOR_DATA-1:0] i_fu_data_flatten;
    logic [NUM_FU-1:0]                   o_fu_ready;
    logic                                o_cdb_valid;
    logic [BW_TAG-1:0]                   o_cdb_tag;
    logic signed [BW_PROCESSOR_DATA-1:0] o_cdb_data;
    logic [BW_FU_IDX-1:0]                o_cdb_src;

    modport master (
        output i_fu_valid, i_fu_tag_flatten, i_fu_data_flatten,
        input  o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src
    );

    modport slave (
        input  i_fu_valid, i_fu_tag_flatten, i_fu_data_flatten,
        output o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter placing one functional-unit result per cycle onto the
// Common Data Bus. Grant is combinational; the broadcast is registered (one
// cycle latency). The CDB has no backpressure, so some requester is granted
// every cycle any request is present.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cdb_arbiter_if.slave (requests in, grants and CDB out)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU            = 4,
    parameter int BW_TAG            = 4,
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_FU_IDX         = $clog2(NUM_FU)
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);

    // Packed views share the flattened layout, so a plain assign unpacks them.
    logic [NUM_FU-1:0][BW_TAG-1:0]            tags;
    logic [NUM_FU-1:0][BW_PROCESSOR_DATA-1:0] datas;
    assign tags  = bus.i_fu_tag_flatten;
    assign datas = bus.i_fu_data_flatten;

    logic [BW_FU_IDX-1:0] rr_ptr;
    logic [BW_FU_IDX-1:0] gnt_idx;
    logic [BW_FU_IDX-1:0] ptr_nxt;
    logic [NUM_FU-1:0]    grant;
    logic                 any_req;

    // Scan rr_ptr, rr_ptr+1, ... with wrap; first valid source wins.
    always_comb begin
        int                   k;
        logic [BW_FU_IDX-1:0] idx;
        grant   = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        k       = 0;
        idx     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_FU) k = k - NUM_FU;
            idx = BW_FU_IDX'(k);
            if (!any_req && bus.i_fu_valid[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    // Explicit wrap keeps non-power-of-two NUM_FU correct.
    assign ptr_nxt = (gnt_idx == BW_FU_IDX'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;

    assign bus.o_fu_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            bus.o_cdb_valid <= 1'b0;
            bus.o_cdb_tag   <= '0;
            bus.o_cdb_data  <= '0;
            bus.o_cdb_src   <= '0;
        end else if (any_req) begin
            rr_ptr          <= ptr_nxt;
            bus.o_cdb_valid <= 1'b1;
            bus.o_cdb_tag   <= tags[gnt_idx];
            bus.o_cdb_data  <= datas[gnt_idx];
            bus.o_cdb_src   <= gnt_idx;
        end else begin
            // Idle cycle: strobe drops, payload holds for debug visibility.
            bus.o_cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter (NUM_FU=4, BW_TAG=4, 32-bit data). Inputs are
// driven 1 ns after the rising edge; grants are sampled 1 ns later and the
// registered CDB is sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    cdb_arbiter_if #(.NUM_FU(4), .BW_TAG(4), .BW_PROCESSOR_DATA(32)) bus ();

    cdb_arbiter #(.NUM_FU(4), .BW_TAG(4), .BW_PROCESSOR_DATA(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] k, input logic v, input logic [3:0] t,
                       input logic [31:0] d);
        bus.i_fu_valid[k]                = v;
        bus.i_fu_tag_flatten[k*4 +: 4]   = t;
        bus.i_fu_data_flatten[k*32 +: 32] = d;
    endtask

    task automatic chk_cdb(input string tag, input logic v, input logic [3:0] t,
                           input logic [31:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(bus.o_cdb_valid), 32'(v));
        chk({tag, ".tag"},   32'(bus.o_cdb_tag),   32'(t));
        chk({tag, ".data"},  bus.o_cdb_data,       d);
        chk({tag, ".src"},   32'(bus.o_cdb_src),   32'(s));
    endtask

    initial begin
        int exp_g [6];
        exp_g = '{0, 1, 2, 3, 0, 1};
        bus.i_fu_valid        = '0;
        bus.i_fu_tag_flatten  = '0;
        bus.i_fu_data_flatten = '0;

        // Reset state
        #1;
        chk_cdb("reset", 1'b0, 4'd0, 32'd0, 2'd0);
        chk("reset.ready", 32'(bus.o_fu_ready), 32'd0);
        chk("reset.rr", 32'(dut.rr_ptr), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // Idle for 5 cycles
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle.valid", 32'(bus.o_cdb_valid), 32'd0);
            chk("idle.ready", 32'(bus.o_fu_ready), 32'd0);
            chk("idle.rr", 32'(dut.rr_ptr), 32'd0);
        end

        // All four request from rr_ptr=0: order 0,1,2,3,0,1
        for (int k = 0; k < 4; k++) req(2'(k), 1'b1, 4'(k + 1), 32'(100 + k));
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr4.ready", 32'(bus.o_fu_ready), 32'd1 << exp_g[c]);
            step();
            chk_cdb("rr4.cdb", 1'b1, 4'(exp_g[c] + 1), 32'(100 + exp_g[c]), 2'(exp_g[c]));
        end
        chk("rr4.rr", 32'(dut.rr_ptr), 32'd2);
        for (int k = 0; k < 4; k++) req(2'(k), 1'b0, 4'd0, 32'd0);

        // Single requester: source 2, tag 5, data -7, three cycles
        req(2'd2, 1'b1, 4'd5, -32'sd7);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("single.ready", 32'(bus.o_fu_ready), 32'b0100);
            step();
            chk_cdb("single.cdb", 1'b1, 4'd5, 32'hFFFF_FFF9, 2'd2);
            chk("single.rr", 32'(dut.rr_ptr), 32'd3);
        end
        req(2'd2, 1'b0, 4'd5, -32'sd7);
        #1;
        chk("drop.ready", 32'(bus.o_fu_ready), 32'd0);
        step();
        chk_cdb("drop.hold", 1'b0, 4'd5, 32'hFFFF_FFF9, 2'd2);

        // rr_ptr=3, sources 0 and 1: wrap to 0 first, then 1
        req(2'd0, 1'b1, 4'd6, 32'd200);
        req(2'd1, 1'b1, 4'd7, 32'd201);
        #1;
        chk("wrap.ready0", 32'(bus.o_fu_ready), 32'b0001);
        step();
        chk_cdb("wrap.cdb0", 1'b1, 4'd6, 32'd200, 2'd0);
        chk("wrap.rr0", 32'(dut.rr_ptr), 32'd1);
        req(2'd0, 1'b0, 4'd0, 32'd0);
        #1;
        chk("wrap.ready1", 32'(bus.o_fu_ready), 32'b0010);
        step();
        chk_cdb("wrap.cdb1", 1'b1, 4'd7, 32'd201, 2'd1);
        chk("wrap.rr1", 32'(dut.rr_ptr), 32'd2);
        req(2'd1, 1'b0, 4'd0, 32'd0);

        // Bring rr_ptr to 0 via a lone grant to source 3
        req(2'd3, 1'b1, 4'd8, 32'd300);
        #1;
        chk("prep.ready", 32'(bus.o_fu_ready), 32'b1000);
        step();
        chk("prep.rr", 32'(dut.rr_ptr), 32'd0);

        // Sources 0 and 3; source 0 re-asserts with tag 9 after its transfer
        req(2'd0, 1'b1, 4'd1, 32'd400);
        req(2'd3, 1'b1, 4'd3, 32'd301);
        #1;
        chk("reass.ready0", 32'(bus.o_fu_ready), 32'b0001);
        step();
        chk_cdb("reass.cdb0", 1'b1, 4'd1, 32'd400, 2'd0);
        req(2'd0, 1'b1, 4'd9, 32'd401);
        #1;
        chk("reass.ready3", 32'(bus.o_fu_ready), 32'b1000);
        step();
        chk_cdb("reass.cdb3", 1'b1, 4'd3, 32'd301, 2'd3);
        chk("reass.rr3", 32'(dut.rr_ptr), 32'd0);
        req(2'd3, 1'b0, 4'd0, 32'd0);
        #1;
        chk("reass.ready0b", 32'(bus.o_fu_ready), 32'b0001);
        step();
        chk_cdb("reass.cdb0b", 1'b1, 4'd9, 32'd401, 2'd0);
        chk("reass.rr0b", 32'(dut.rr_ptr), 32'd1);

        // Async reset mid-stream while o_cdb_valid=1
        #2;
        rst_n = 1'b0;
        #1;
        chk_cdb("async", 1'b0, 4'd0, 32'd0, 2'd0);
        chk("async.rr", 32'(dut.rr_ptr), 32'd0);
        req(2'd0, 1'b0, 4'd0, 32'd0);
        req(2'd1, 1'b1, 4'd10, 32'd500);
        req(2'd2, 1'b1, 4'd11, 32'd501);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post.ready1", 32'(bus.o_fu_ready), 32'b0010);
        step();
        chk_cdb("post.cdb1", 1'b1, 4'd10, 32'd500, 2'd1);
        chk("post.rr1", 32'(dut.rr_ptr), 32'd2);
        req(2'd1, 1'b0, 4'd0, 32'd0);
        #1;
        chk("post.ready2", 32'(bus.o_fu_ready), 32'b0100);
        step();
        chk_cdb("post.cdb2", 1'b1, 4'd11, 32'd501, 2'd2);
        chk("post.rr2", 32'(dut.rr_ptr), 32'd3);
        req(2'd2, 1'b0, 4'd0, 32'd0);
        step();
        chk("post.idle", 32'(bus.o_cdb_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates result broadcasts from all functional units onto the single Common Data Bus. Sources include the load/store unit's load-broadcast port, the ALUs and the multiplier.
- Sits directly downstream of each unit's valid/ready CDB output port.
- Drives the registered CDB valid/tag/data seen by every reservation station, the register status table and the load/store reservation station's CDB input.
- Grants one source per cycle, round-robin, with a one-cycle registered output.

Parameters:
NUM_FU, 4, number of requesting functional units (>=2); index 0 is the load/store unit by integration convention.
BW_TAG, 4, reservation-station tag width.
BW_PROCESSOR_DATA, 32, broadcast data width.
BW_FU_IDX, $clog2(NUM_FU), width of the source index.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
i_fu_valid  input  NUM_FU  per-source broadcast request.
o_fu_ready  output  NUM_FU  per-source grant; at most one bit set; combinational from i_fu_valid and rr_ptr.
i_fu_tag_flatten  input  NUM_FU*BW_TAG  source k tag in bits [k*BW_TAG +: BW_TAG].
i_fu_data_flatten  input  NUM_FU*BW_PROCESSOR_DATA  source k data, signed, same packing.
o_cdb_valid  output  1  registered broadcast strobe.
o_cdb_tag  output  BW_TAG  registered broadcast tag.
o_cdb_data  output  BW_PROCESSOR_DATA  registered broadcast data, signed.
o_cdb_src  output  BW_FU_IDX  registered index of the granted source, for debug/performance counters.

Behaviour:
- Reset (async, rst_n=0): o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_src=0, rr_ptr=0. o_fu_ready is combinational and is all-zero while all i_fu_valid are 0.
- Handshake per source:
  - Transfer occurs when i_fu_valid[k] & o_fu_ready[k] on a rising edge.
  - A source holds valid, tag and data stable until transferred.
  - o_fu_ready[k] never asserts unless i_fu_valid[k]=1.
  - Valid must not drop before transfer; behaviour otherwise is undefined, but the arbiter must not broadcast a source whose valid is low.
- The CDB has no backpressure: the arbiter grants exactly one requester every cycle in which any i_fu_valid bit is 1.
- Grant selection: the first k with i_fu_valid[k]=1, scanning rr_ptr, rr_ptr+1, ..., NUM_FU-1, 0, ..., rr_ptr-1 (wrap-around modulo NUM_FU).
- Pointer update:
  - On a grant to k, rr_ptr <= (k+1) mod NUM_FU. When k=NUM_FU-1 this wraps to 0.
  - No request: rr_ptr unchanged.
- Output register, latency 1 cycle:
  - On a grant to k in cycle t, in cycle t+1: o_cdb_valid=1, o_cdb_tag=tag[k], o_cdb_data=data[k], o_cdb_src=k.
  - No grant in cycle t: o_cdb_valid=0 in t+1; tag, data and src hold their previous values.
- Throughput: one broadcast per cycle sustained. Back-to-back grants to different sources give o_cdb_valid continuously high.
- Fairness: a continuously requesting source waits at most NUM_FU-1 cycles for a grant.
- Single requester: granted every cycle it requests (e.g. a streaming load unit with no contention).
- A source may re-assert valid with new data in the cycle after its transfer. It is arbitrated normally; rr_ptr has already moved past it.
- Reset mid-operation: pending requests are dropped by the arbiter. o_cdb_valid is forced to 0 immediately (async). After release, arbitration restarts from rr_ptr=0.
- Tag value is passed through unmodified; no checking of tag 0.
- Flush/misprediction is handled inside the sources; the arbiter has no speculation input.

Test Plan:
1. Reset, then no requests for 5 cycles -> o_cdb_valid=0, o_fu_ready=0000, rr_ptr=0 throughout.
2. NUM_FU=4. Only source 2 requests, tag=5, data=-7, held 3 cycles -> o_fu_ready=0100 each cycle; o_cdb_valid=1 with tag 5, data -7, src 2 starting one cycle later, for 3 consecutive cycles.
3. All four request continuously from rr_ptr=0 -> grant order 0,1,2,3,0,1; o_cdb_src follows the same sequence delayed one cycle; o_cdb_valid stays high.
4. rr_ptr=3 (after granting 2); sources 0 and 1 request -> grant 0 first (wrap past 3), then 1; rr_ptr becomes 1, then 2.
5. Source 0 (load unit) and source 3 request; source 0 is granted and re-asserts with new tag 9 next cycle -> source 3 is granted second, then source 0 with tag 9. Neither waits more than 3 cycles.
6. Assert rst_n=0 mid-stream while o_cdb_valid=1 -> o_cdb_valid=0 without waiting for a clock edge; after release with sources 1 and 2 requesting, source 1 is granted first.
